// File: rtl/hb_decim_feed_ctrl.sv
// hb_decim_feed_ctrl
// Front-end sequencer for an x2 halfband decimator stage. Splits a serial
// complex sample stream into polyphase pairs (older sample -> delay path,
// newer sample -> direct path), pads odd bursts, and drains the filter tap
// lines with a run of zero pairs after each burst.
//
// Handshake: i_valid is a one-cycle sample strobe with no backpressure; a
// sample is taken on every rising edge where i_valid=1 and the block is
// accepting. o_valid is a one-cycle pair strobe, registered, appearing one
// cycle after the input that completes the pair; data outputs hold between
// strobes. The FSM state is exported on o_dbg_state (0=IDLE, 1=RUN, 2=FLUSH).

module hb_decim_feed_ctrl #(
    parameter int WIDTH       = 16,
    parameter int FLUSH_PAIRS = 8,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_phase_sel,
    input  logic [WIDTH-1:0]     i_inph_data,
    input  logic [WIDTH-1:0]     i_quad_data,
    input  logic                 i_valid,
    input  logic                 i_last,
    output logic [WIDTH-1:0]     o_inph_data,
    output logic [WIDTH-1:0]     o_quad_data,
    output logic [WIDTH-1:0]     o_inph_delay_data,
    output logic [WIDTH-1:0]     o_quad_delay_data,
    output logic                 o_valid,
    output logic                 o_busy,
    output logic                 o_flush_done,
    output logic                 o_overrun,
    output logic [CNT_WIDTH-1:0] o_pair_count,
    output logic [1:0]           o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    localparam logic [7:0]           FLUSH_LAST = 8'(FLUSH_PAIRS - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

    state_t               state_q, state_d;
    logic                 hold_full_q, hold_full_d;
    logic [WIDTH-1:0]     hold_i_q, hold_i_d;
    logic [WIDTH-1:0]     hold_q_q, hold_q_d;
    logic [7:0]           flush_cnt_q, flush_cnt_d;
    logic [WIDTH-1:0]     out_i_q, out_i_d;
    logic [WIDTH-1:0]     out_q_q, out_q_d;
    logic [WIDTH-1:0]     out_di_q, out_di_d;
    logic [WIDTH-1:0]     out_dq_q, out_dq_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;
    logic                 overrun_q, overrun_d;
    logic [CNT_WIDTH-1:0] pair_count_q, pair_count_d;

    // Pair-building scratch signals used inside the next-state logic.
    logic                 emit;
    logic                 count_pair;
    logic                 clear_count;
    logic [WIDTH-1:0]     emit_di, emit_dq, emit_i, emit_q;
    logic [CNT_WIDTH-1:0] cnt_base;

    // Next-state logic: FSM transitions, pairing, padding and flush sequencing.
    always_comb begin
        state_d      = state_q;
        hold_full_d  = hold_full_q;
        hold_i_d     = hold_i_q;
        hold_q_d     = hold_q_q;
        flush_cnt_d  = flush_cnt_q;
        overrun_d    = overrun_q;
        done_d       = 1'b0;
        emit         = 1'b0;
        count_pair   = 1'b0;
        clear_count  = 1'b0;
        emit_di      = '0;
        emit_dq      = '0;
        emit_i       = '0;
        emit_q       = '0;

        case (state_q)
            S_IDLE: begin
                if (i_enable && i_valid) begin
                    clear_count = 1'b1;
                    overrun_d   = 1'b0;
                    flush_cnt_d = '0;
                    if (i_phase_sel) begin
                        // First sample discarded to shift the pairing by one.
                        hold_full_d = 1'b0;
                        state_d     = i_last ? S_FLUSH : S_RUN;
                    end else if (i_last) begin
                        // Single-sample burst: pad it out immediately.
                        emit        = 1'b1;
                        count_pair  = 1'b1;
                        emit_di     = i_inph_data;
                        emit_dq     = i_quad_data;
                        hold_full_d = 1'b0;
                        state_d     = S_FLUSH;
                    end else begin
                        hold_i_d    = i_inph_data;
                        hold_q_d    = i_quad_data;
                        hold_full_d = 1'b1;
                        state_d     = S_RUN;
                    end
                end
            end

            S_RUN: begin
                if (!i_enable) begin
                    // Abort: the held sample is dropped, count stays put.
                    hold_full_d = 1'b0;
                    state_d     = S_IDLE;
                end else if (i_valid) begin
                    if (hold_full_q) begin
                        emit        = 1'b1;
                        count_pair  = 1'b1;
                        emit_di     = hold_i_q;
                        emit_dq     = hold_q_q;
                        emit_i      = i_inph_data;
                        emit_q      = i_quad_data;
                        hold_full_d = 1'b0;
                    end else if (i_last) begin
                        // Odd burst end: current sample becomes the older
                        // half of a pad pair with zero on the direct path.
                        emit        = 1'b1;
                        count_pair  = 1'b1;
                        emit_di     = i_inph_data;
                        emit_dq     = i_quad_data;
                    end else begin
                        hold_i_d    = i_inph_data;
                        hold_q_d    = i_quad_data;
                        hold_full_d = 1'b1;
                    end
                    if (i_last) begin
                        hold_full_d = 1'b0;
                        flush_cnt_d = '0;
                        state_d     = S_FLUSH;
                    end
                end
            end

            S_FLUSH: begin
                if (!i_enable) begin
                    flush_cnt_d = '0;
                    state_d     = S_IDLE;
                end else begin
                    if (i_valid) begin
                        overrun_d = 1'b1;
                    end
                    // Zero pair every cycle; emit_* defaults are already zero.
                    emit = 1'b1;
                    if (flush_cnt_q == FLUSH_LAST) begin
                        done_d      = 1'b1;
                        flush_cnt_d = '0;
                        state_d     = S_IDLE;
                    end else begin
                        flush_cnt_d = flush_cnt_q + 8'd1;
                    end
                end
            end

            default: begin
                hold_full_d = 1'b0;
                flush_cnt_d = '0;
                state_d     = S_IDLE;
            end
        endcase

        // Pair counter: cleared at burst start, saturating increment.
        cnt_base = clear_count ? '0 : pair_count_q;
        if (count_pair && (cnt_base != CNT_MAX)) begin
            pair_count_d = cnt_base + CNT_WIDTH'(1);
        end else begin
            pair_count_d = cnt_base;
        end

        // Output registers only update when a pair is issued.
        valid_d  = emit;
        out_di_d = emit ? emit_di : out_di_q;
        out_dq_d = emit ? emit_dq : out_dq_q;
        out_i_d  = emit ? emit_i  : out_i_q;
        out_q_d  = emit ? emit_q  : out_q_q;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q      <= S_IDLE;
            hold_full_q  <= 1'b0;
            hold_i_q     <= '0;
            hold_q_q     <= '0;
            flush_cnt_q  <= '0;
            out_i_q      <= '0;
            out_q_q      <= '0;
            out_di_q     <= '0;
            out_dq_q     <= '0;
            valid_q      <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
            pair_count_q <= '0;
        end else begin
            state_q      <= state_d;
            hold_full_q  <= hold_full_d;
            hold_i_q     <= hold_i_d;
            hold_q_q     <= hold_q_d;
            flush_cnt_q  <= flush_cnt_d;
            out_i_q      <= out_i_d;
            out_q_q      <= out_q_d;
            out_di_q     <= out_di_d;
            out_dq_q     <= out_dq_d;
            valid_q      <= valid_d;
            done_q       <= done_d;
            overrun_q    <= overrun_d;
            pair_count_q <= pair_count_d;
        end
    end

    assign o_inph_data       = out_i_q;
    assign o_quad_data       = out_q_q;
    assign o_inph_delay_data = out_di_q;
    assign o_quad_delay_data = out_dq_q;
    assign o_valid           = valid_q;
    assign o_flush_done      = done_q;
    assign o_overrun         = overrun_q;
    assign o_pair_count      = pair_count_q;
    assign o_busy            = (state_q != S_IDLE);
    assign o_dbg_state       = state_q;

endmodule
